// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/adjust controller for the stopwatch digit counter.
// Raw buttons and switches are synchronised and debounced. A mode FSM then
// produces registered strobes for the digit counter: 1 Hz tick, clear and
// adjust-increment.
// Optional feature macro: STOPWATCH_ADJUST_EN enables the ADJUST mode, the
// adjust prescaler and the adj_inc/adj_sel/blink outputs. When the macro is
// undefined, those outputs are tied low.

// Two-flop synchroniser followed by a counter debouncer for one raw input.
module stopwatch_ctrl_sync_db #(
    parameter int unsigned DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);
    localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          meta_q, meta_d;
    logic          sync_q, sync_d;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Debounce: adopt the synced value once it has disagreed for DB_CYCLES samples
    always_comb begin
        meta_d  = raw;
        sync_d  = meta_q;
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Synchroniser, debounced level and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            meta_q  <= meta_d;
            sync_q  <= sync_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
endmodule

module stopwatch_ctrl #(
    parameter int unsigned CLK_HZ    = 100000000,
    parameter int unsigned DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_pause,
    input  logic btn_clr,
    input  logic sw_adj,
    input  logic sw_sel,
    output logic tick,
    output logic clear,
    output logic paused,
    output logic adj_inc,
    output logic adj_sel,
    output logic blink
);
    localparam int unsigned PW = $clog2(CLK_HZ);
    localparam logic [PW-1:0] P_LAST = PW'(CLK_HZ - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, ADJUST} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] p_q, p_d;
    logic          tick_q, tick_d;
    logic          clear_q, clear_d;
    logic          paused_q, paused_d;
    logic          pause_prev_q, clr_prev_q;

    logic pause_lvl, clr_lvl, adj_lvl, sel_lvl;
    logic pause_press, clr_press;

    stopwatch_ctrl_sync_db #(.DB_CYCLES(DB_CYCLES)) u_db_pause (
        .clk(clk), .rst(rst), .raw(btn_pause), .level(pause_lvl)
    );
    stopwatch_ctrl_sync_db #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
        .clk(clk), .rst(rst), .raw(btn_clr), .level(clr_lvl)
    );

`ifdef STOPWATCH_ADJUST_EN
    localparam int unsigned A_N  = CLK_HZ / 2;
    localparam int unsigned B_N  = CLK_HZ / 4;
    localparam int unsigned AW   = $clog2(A_N);
    localparam int unsigned BW   = (B_N > 1) ? $clog2(B_N) : 1;
    localparam logic [AW-1:0] A_LAST = AW'(A_N - 1);
    localparam logic [BW-1:0] B_LAST = BW'(B_N - 1);

    logic [AW-1:0] a_q, a_d;
    logic [BW-1:0] b_q, b_d;
    logic          adj_inc_q, adj_inc_d;
    logic          adj_sel_q, adj_sel_d;
    logic          blink_q, blink_d;

    stopwatch_ctrl_sync_db #(.DB_CYCLES(DB_CYCLES)) u_db_adj (
        .clk(clk), .rst(rst), .raw(sw_adj), .level(adj_lvl)
    );
    stopwatch_ctrl_sync_db #(.DB_CYCLES(DB_CYCLES)) u_db_sel (
        .clk(clk), .rst(rst), .raw(sw_sel), .level(sel_lvl)
    );
`else
    logic unused_adj_inputs;
    assign unused_adj_inputs = sw_adj ^ sw_sel;
    assign adj_lvl = 1'b0;
    assign sel_lvl = 1'b0;
`endif

    assign pause_press = pause_lvl & ~pause_prev_q;
    assign clr_press   = clr_lvl & ~clr_prev_q;

    // Mode transitions: clear press beats the adjust level, which beats a pause press
    always_comb begin
        state_d = state_q;
        clear_d = 1'b0;
        if (clr_press) begin
            state_d = IDLE;
            clear_d = 1'b1;
        end else if (adj_lvl && (state_q != ADJUST)) begin
            state_d = ADJUST;
        end else if (!adj_lvl && (state_q == ADJUST)) begin
            state_d = PAUSE;
        end else if (pause_press) begin
            case (state_q)
                IDLE:    state_d = RUN;
                RUN:     state_d = PAUSE;
                PAUSE:   state_d = RUN;
                default: state_d = state_q;
            endcase
        end
        paused_d = (state_d != RUN);
    end

    // One-second prescaler: counts only while running, so a pause keeps the partial second
    always_comb begin
        p_d    = p_q;
        tick_d = 1'b0;
        if (clr_press) begin
            p_d = '0;
        end else if (state_q == RUN) begin
            if (p_q == P_LAST) begin
                p_d    = '0;
                tick_d = 1'b1;
            end else begin
                p_d = p_q + PW'(1);
            end
        end
    end

`ifdef STOPWATCH_ADJUST_EN
    // Adjust timing: half-second increment strobe and quarter-second blink, restarted on entry
    always_comb begin
        a_d       = '0;
        b_d       = '0;
        adj_inc_d = 1'b0;
        blink_d   = 1'b0;
        adj_sel_d = (state_d == ADJUST) & sel_lvl;
        if (state_d == ADJUST) begin
            if (state_q != ADJUST) begin
                blink_d = 1'b1;
            end else begin
                if (a_q == A_LAST) begin
                    adj_inc_d = 1'b1;
                end else begin
                    a_d = a_q + AW'(1);
                end
                if (b_q == B_LAST) begin
                    blink_d = ~blink_q;
                end else begin
                    b_d     = b_q + BW'(1);
                    blink_d = blink_q;
                end
            end
        end
    end
`endif

    // State, prescalers, edge-detect history and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            p_q          <= '0;
            tick_q       <= 1'b0;
            clear_q      <= 1'b0;
            paused_q     <= 1'b1;
            pause_prev_q <= 1'b0;
            clr_prev_q   <= 1'b0;
`ifdef STOPWATCH_ADJUST_EN
            a_q          <= '0;
            b_q          <= '0;
            adj_inc_q    <= 1'b0;
            adj_sel_q    <= 1'b0;
            blink_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            p_q          <= p_d;
            tick_q       <= tick_d;
            clear_q      <= clear_d;
            paused_q     <= paused_d;
            pause_prev_q <= pause_lvl;
            clr_prev_q   <= clr_lvl;
`ifdef STOPWATCH_ADJUST_EN
            a_q          <= a_d;
            b_q          <= b_d;
            adj_inc_q    <= adj_inc_d;
            adj_sel_q    <= adj_sel_d;
            blink_q      <= blink_d;
`endif
        end
    end

    assign tick   = tick_q;
    assign clear  = clear_q;
    assign paused = paused_q;
`ifdef STOPWATCH_ADJUST_EN
    assign adj_inc = adj_inc_q;
    assign adj_sel = adj_sel_q;
    assign blink   = blink_q;
`else
    assign adj_inc = 1'b0;
    assign adj_sel = 1'b0;
    assign blink   = 1'b0;
`endif
endmodule
